ram_arbiter_d0: RTL and testbench
=================================

RAM_ARBITER_D0 -- requirements
Module: ram_arbiter_d0

Interface
REQ-001 SHALL have parameter AWIDTH, default 3: address width; DEPTH = 2**AWIDTH.
REQ-002 SHALL have parameter DWIDTH, default 32: data width.
REQ-003 SHALL have port clock, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have ports req0_valid / req1_valid, input, 1: requester i presents a command.
REQ-006 SHALL have ports req0_we / req1_we, input, 1: 1 = write, 0 = read.
REQ-007 SHALL have ports req0_addr / req1_addr, input, AWIDTH: command address.
REQ-008 SHALL have ports req0_wdata / req1_wdata, input, DWIDTH: write data.
REQ-009 SHALL have ports req0_ready / req1_ready, output, 1: command accepted this cycle.
REQ-010 SHALL have ports rsp0_valid / rsp1_valid, output, 1: read data valid for requester i.
REQ-011 SHALL have ports rsp0_rdata / rsp1_rdata, output, DWIDTH: read data.
REQ-012 SHALL have port init_done, output, 1: memory clear complete, commands accepted.
REQ-013 SHALL have ports ram_addr (AWIDTH), ram_din (DWIDTH), ram_we (1), all outputs: drive the sync-read RAM.
REQ-014 SHALL have port ram_dout, input, DWIDTH: RAM output; it reflects the address latched at the previous edge.

Function
REQ-015 SHALL implement two states: INIT and SERVE.
REQ-016 INIT SHALL drive ram_we=1, ram_din=0 and ram_addr=clear counter, advancing the counter 0..DEPTH-1 one per cycle.
REQ-017 INIT SHALL move to SERVE on the edge that writes address DEPTH-1; init_done is registered and is 1 from that edge on.
REQ-018 INIT SHALL hold req0_ready=req1_ready=0 and rsp*_valid=0.
REQ-019 SERVE SHALL assert ready combinationally to at most one requester per cycle.
REQ-020 SERVE arbitration:
- Only one valid: that requester is granted.
- Both valid: the requester not granted by the last transfer is granted.
- Round-robin pointer updates only on a transfer (valid && ready).
REQ-021 A granted command SHALL drive ram_addr/ram_din/ram_we combinationally in the same cycle; ram_we = granted req_we.
REQ-022 With no grant in SERVE, ram_we SHALL be 0 and ram_addr/ram_din SHALL be 0.
REQ-023 Read response timing:
- A read granted in cycle N asserts rspi_valid for exactly cycle N+1 (registered flag) to the granted requester.
- rspi_rdata = ram_dout in that cycle.
- Writes produce no response.
REQ-024 rspi_rdata SHALL be 0 whenever rspi_valid=0.
REQ-025 Back-to-back reads from the same requester SHALL yield one response per cycle, in order, latency 1.
REQ-026 A write at cycle N followed by a read of the same address at N+1 SHALL return the written data at N+2.
REQ-027 Requesters SHALL hold valid and command fields stable until ready; the block does not buffer ungranted commands.

Reset
REQ-028 reset_n low SHALL asynchronously force the following:
- State INIT, clear counter 0, round-robin pointer favouring req0.
- init_done=0, rsp*_valid=0, ready=0.
- Consequently ram_we=1, ram_addr=0, ram_din=0.
REQ-029 Reset asserted mid-SERVE or mid-INIT SHALL drop any pending response and restart the clear from address 0 after release.

Structure
REQ-030 Package ram_arb_pkg SHALL hold the state enum (INIT, SERVE) and the default AWIDTH/DWIDTH constants.
REQ-031 The two-way round-robin grant logic SHALL be one sub-module, ram_arb_rr2 (inputs valid[1:0], pointer; outputs grant[1:0]).
REQ-032 The RAM itself SHALL NOT be instantiated inside this block.

Verification
REQ-033 Reset release -> ram_we=1 for exactly 8 cycles at addresses 0..7 with din=0; init_done=1 after the 8th edge; afterwards all reads return 0.
REQ-034 req0 write addr 3 = 0xDEADBEEF, then req0 read addr 3 next cycle -> rsp0_valid one cycle later with 0xDEADBEEF; rsp1_valid stays 0.
REQ-035 Both valid reads for 4 cycles (req0 addr 1, req1 addr 2, preloaded 0x11/0x22):
- Grants alternate 0,1,0,1.
- Responses are 0x11,0x22,0x11,0x22 on rsp0/rsp1 alternately.
REQ-036 Only req1 valid for 3 cycles -> granted all 3 cycles; a then-simultaneous request grants req0 first.
REQ-037 reset_n pulsed low while a read is granted -> no rsp_valid after release; INIT reruns from address 0.
REQ-038 Request asserted during INIT -> ready=0 until init_done=1; the command is granted in the first SERVE cycle.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types and default widths for the two-port RAM arbiter.
package ram_arb_pkg;

    localparam int unsigned AWIDTH_DEF = 3;
    localparam int unsigned DWIDTH_DEF = 32;

    typedef enum logic {
        StInit,
        StServe
    } state_e;

endpackage

// File: rtl/ram_arb_rr2.sv
// Two-way round-robin grant; ptr=0 favours requester 0 when both are valid.
module ram_arb_rr2 (
    input  logic [1:0] valid,
    input  logic       ptr,
    output logic [1:0] grant
);

    assign grant[0] = valid[0] & (~valid[1] | ~ptr);
    assign grant[1] = valid[1] & (~valid[0] | ptr);

endmodule

// File: rtl/ram_arbiter_d0.sv
// Arbitrates two command ports onto one sync-read RAM after clearing it to zero.
module ram_arbiter_d0
    import ram_arb_pkg::*;
#(
    parameter int unsigned AWIDTH = AWIDTH_DEF,
    parameter int unsigned DWIDTH = DWIDTH_DEF
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req0_valid,
    input  logic              req0_we,
    input  logic [AWIDTH-1:0] req0_addr,
    input  logic [DWIDTH-1:0] req0_wdata,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic              req1_we,
    input  logic [AWIDTH-1:0] req1_addr,
    input  logic [DWIDTH-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              rsp0_valid,
    output logic [DWIDTH-1:0] rsp0_rdata,
    output logic              rsp1_valid,
    output logic [DWIDTH-1:0] rsp1_rdata,
    output logic              init_done,
    output logic [AWIDTH-1:0] ram_addr,
    output logic [DWIDTH-1:0] ram_din,
    output logic              ram_we,
    input  logic [DWIDTH-1:0] ram_dout
);

    localparam int unsigned DEPTH = 2 ** AWIDTH;

    state_e            state_q;
    logic [AWIDTH-1:0] clr_cnt_q;
    logic              rr_ptr_q;
    logic              init_done_q;
    logic              rsp0_pend_q;
    logic              rsp1_pend_q;
    logic [1:0]        rr_grant;
    logic [1:0]        grant;

    ram_arb_rr2 u_rr (
        .valid ({req1_valid, req0_valid}),
        .ptr   (rr_ptr_q),
        .grant (rr_grant)
    );

    assign grant      = (state_q == StServe) ? rr_grant : 2'b00;
    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign init_done  = init_done_q;
    assign rsp0_valid = rsp0_pend_q;
    assign rsp1_valid = rsp1_pend_q;
    // The RAM presents the addressed word one cycle after the grant.
    assign rsp0_rdata = rsp0_pend_q ? ram_dout : '0;
    assign rsp1_rdata = rsp1_pend_q ? ram_dout : '0;

    always_comb begin
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        if (state_q == StInit) begin
            ram_we   = 1'b1;
            ram_addr = clr_cnt_q;
        end else if (grant[0]) begin
            ram_we   = req0_we;
            ram_addr = req0_addr;
            ram_din  = req0_wdata;
        end else if (grant[1]) begin
            ram_we   = req1_we;
            ram_addr = req1_addr;
            ram_din  = req1_wdata;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StInit;
            clr_cnt_q   <= '0;
            rr_ptr_q    <= 1'b0;
            init_done_q <= 1'b0;
            rsp0_pend_q <= 1'b0;
            rsp1_pend_q <= 1'b0;
        end else begin
            case (state_q)
                StInit: begin
                    clr_cnt_q   <= clr_cnt_q + AWIDTH'(1);
                    rsp0_pend_q <= 1'b0;
                    rsp1_pend_q <= 1'b0;
                    if (clr_cnt_q == AWIDTH'(DEPTH - 1)) begin
                        state_q     <= StServe;
                        init_done_q <= 1'b1;
                    end
                end
                StServe: begin
                    rsp0_pend_q <= grant[0] & ~req0_we;
                    rsp1_pend_q <= grant[1] & ~req1_we;
                    // After serving req0 the pointer favours req1, and vice versa.
                    if (|grant) begin
                        rr_ptr_q <= grant[0];
                    end
                end
                default: state_q <= StInit;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter_d0.sv
// Directed bench for ram_arbiter_d0 with a behavioural sync-read RAM.
module tb_ram_arbiter_d0;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        req0_valid, req0_we, req1_valid, req1_we;
    logic [2:0]  req0_addr, req1_addr;
    logic [31:0] req0_wdata, req1_wdata;
    logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, init_done, ram_we;
    logic [31:0] rsp0_rdata, rsp1_rdata, ram_din, ram_dout;
    logic [2:0]  ram_addr;
    logic [31:0] mem [8] = '{default: 32'hA5A5A5A5};

    int tests_run = 0;
    int tests_failed = 0;

    ram_arbiter_d0 dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req0_valid (req0_valid),
        .req0_we    (req0_we),
        .req0_addr  (req0_addr),
        .req0_wdata (req0_wdata),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_we    (req1_we),
        .req1_addr  (req1_addr),
        .req1_wdata (req1_wdata),
        .req1_ready (req1_ready),
        .rsp0_valid (rsp0_valid),
        .rsp0_rdata (rsp0_rdata),
        .rsp1_valid (rsp1_valid),
        .rsp1_rdata (rsp1_rdata),
        .init_done  (init_done),
        .ram_addr   (ram_addr),
        .ram_din    (ram_din),
        .ram_we     (ram_we),
        .ram_dout   (ram_dout)
    );

    always #5 clock = ~clock;

    // Read-before-write sync RAM: dout shows the word addressed at the previous edge.
    always @(posedge clock) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        req0_valid = 1'b0; req0_we = 1'b0; req0_addr = '0; req0_wdata = '0;
        req1_valid = 1'b0; req1_we = 1'b0; req1_addr = '0; req1_wdata = '0;
    endtask

    task automatic drive0(input logic v, input logic we, input logic [2:0] a,
                          input logic [31:0] d);
        req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = d;
    endtask

    task automatic drive1(input logic v, input logic we, input logic [2:0] a,
                          input logic [31:0] d);
        req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = d;
    endtask

    task automatic test_reset();
        idle();
        reset_n = 1'b0;
        req0_valid = 1'b1;
        tick();
        #4;
        tests_run++;
        if ({ram_we, ram_addr, init_done, req0_ready, req1_ready, rsp0_valid, rsp1_valid}
            !== {1'b1, 3'd0, 5'b00000} || ram_din !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_hold: we=%b addr=%0d din=%h done=%b rdy=%b%b rsp=%b%b, want 1 0 0 0 00 00",
                     ram_we, ram_addr, ram_din, init_done, req1_ready, req0_ready,
                     rsp1_valid, rsp0_valid);
        end
        idle();
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #4;
            tests_run++;
            if (ram_we !== 1'b1 || ram_addr !== 3'(i) || ram_din !== 32'd0 || init_done !== 1'b0)
            begin
                tests_failed++;
                $display("FAIL init_clear[%0d]: we=%b addr=%0d din=%h done=%b, want 1 %0d 0 0",
                         i, ram_we, ram_addr, ram_din, init_done, i);
            end
            tick();
        end
        #4;
        tests_run++;
        if (init_done !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 3'd0 || ram_din !== 32'd0) begin
            tests_failed++;
            $display("FAIL init_end: done=%b we=%b addr=%0d din=%h, want 1 0 0 0",
                     init_done, ram_we, ram_addr, ram_din);
        end
        tick();
    endtask

    task automatic test_reads_zero();
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) drive0(1'b1, 1'b0, 3'(i), 32'd0);
            else idle();
            #4;
            if (i < 8) begin
                tests_run++;
                if ({req1_ready, req0_ready} !== 2'b01 || ram_addr !== 3'(i) || ram_we !== 1'b0)
                begin
                    tests_failed++;
                    $display("FAIL b2b_grant[%0d]: rdy=%b%b addr=%0d we=%b, want 01 %0d 0",
                             i, req1_ready, req0_ready, ram_addr, ram_we, i);
                end
            end
            if (i > 0) begin
                tests_run++;
                if (rsp0_valid !== 1'b1 || rsp0_rdata !== 32'd0 || rsp1_valid !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL b2b_rsp[%0d]: v0=%b d0=%h v1=%b, want 1 0 0",
                             i - 1, rsp0_valid, rsp0_rdata, rsp1_valid);
                end
            end
            tick();
        end
    endtask

    task automatic test_write_read();
        drive0(1'b1, 1'b1, 3'd3, 32'hDEADBEEF);
        #4;
        tests_run++;
        if (req0_ready !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 3'd3 || ram_din !== 32'hDEADBEEF)
        begin
            tests_failed++;
            $display("FAIL wr_cmd: rdy=%b we=%b addr=%0d din=%h, want 1 1 3 deadbeef",
                     req0_ready, ram_we, ram_addr, ram_din);
        end
        tick();
        drive0(1'b1, 1'b0, 3'd3, 32'd0);
        #4;
        tests_run++;
        if (req0_ready !== 1'b1 || ram_we !== 1'b0 || rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0)
        begin
            tests_failed++;
            $display("FAIL rd_cmd: rdy=%b we=%b v0=%b v1=%b, want 1 0 0 0",
                     req0_ready, ram_we, rsp0_valid, rsp1_valid);
        end
        tick();
        idle();
        #4;
        tests_run++;
        if (rsp0_valid !== 1'b1 || rsp0_rdata !== 32'hDEADBEEF || rsp1_valid !== 1'b0 ||
            rsp1_rdata !== 32'd0 || ram_we !== 1'b0 || ram_addr !== 3'd0 || ram_din !== 32'd0)
        begin
            tests_failed++;
            $display("FAIL rd_rsp: v0=%b d0=%h v1=%b d1=%h we=%b addr=%0d din=%h, want 1 deadbeef 0 0 0 0 0",
                     rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata, ram_we, ram_addr, ram_din);
        end
        tick();
        #4;
        tests_run++;
        if (rsp0_valid !== 1'b0 || rsp0_rdata !== 32'd0) begin
            tests_failed++;
            $display("FAIL rsp_one_cycle: v0=%b d0=%h, want 0 0", rsp0_valid, rsp0_rdata);
        end
        tick();
    endtask

    task automatic test_alternate();
        drive0(1'b1, 1'b1, 3'd1, 32'h11);
        #4;
        tests_run++;
        if (req0_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL preload0: rdy0=%b, want 1", req0_ready);
        end
        tick();
        idle();
        drive1(1'b1, 1'b1, 3'd2, 32'h22);
        #4;
        tests_run++;
        if (req1_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL preload1: rdy1=%b, want 1", req1_ready);
        end
        tick();
        drive0(1'b1, 1'b0, 3'd1, 32'd0);
        drive1(1'b1, 1'b0, 3'd2, 32'd0);
        for (int k = 0; k <= 4; k++) begin
            if (k == 4) idle();
            #4;
            if (k < 4) begin
                tests_run++;
                if ({req1_ready, req0_ready} !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
                    tests_failed++;
                    $display("FAIL alt_grant[%0d]: rdy=%b%b, want %s",
                             k, req1_ready, req0_ready, (k % 2 == 0) ? "01" : "10");
                end
            end
            if (k > 0) begin
                tests_run++;
                if ((k % 2 == 1) ? ({rsp1_valid, rsp0_valid} !== 2'b01 || rsp0_rdata !== 32'h11)
                                 : ({rsp1_valid, rsp0_valid} !== 2'b10 || rsp1_rdata !== 32'h22))
                begin
                    tests_failed++;
                    $display("FAIL alt_rsp[%0d]: v=%b%b d0=%h d1=%h, want %s",
                             k - 1, rsp1_valid, rsp0_valid, rsp0_rdata, rsp1_rdata,
                             (k % 2 == 1) ? "01 d0=11" : "10 d1=22");
                end
            end
            tick();
        end
    endtask

    task automatic test_req1_only();
        idle();
        drive1(1'b1, 1'b0, 3'd2, 32'd0);
        for (int k = 0; k < 3; k++) begin
            #4;
            tests_run++;
            if ({req1_ready, req0_ready} !== 2'b10) begin
                tests_failed++;
                $display("FAIL solo1_grant[%0d]: rdy=%b%b, want 10", k, req1_ready, req0_ready);
            end
            tick();
        end
        drive0(1'b1, 1'b0, 3'd1, 32'd0);
        #4;
        tests_run++;
        if ({req1_ready, req0_ready} !== 2'b01 || rsp1_valid !== 1'b1 || rsp1_rdata !== 32'h22)
        begin
            tests_failed++;
            $display("FAIL solo1_then_both: rdy=%b%b v1=%b d1=%h, want 01 1 22",
                     req1_ready, req0_ready, rsp1_valid, rsp1_rdata);
        end
        tick();
        idle();
        #4;
        tests_run++;
        if (rsp0_valid !== 1'b1 || rsp0_rdata !== 32'h11 || rsp1_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL solo1_rsp0: v0=%b d0=%h v1=%b, want 1 11 0",
                     rsp0_valid, rsp0_rdata, rsp1_valid);
        end
        tick();
    endtask

    task automatic test_reset_mid_read();
        drive0(1'b1, 1'b0, 3'd1, 32'd0);
        #4;
        tests_run++;
        if (req0_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_rd_grant: rdy0=%b, want 1", req0_ready);
        end
        #2;
        reset_n = 1'b0;
        #1;
        tests_run++;
        if (req0_ready !== 1'b0 || ram_we !== 1'b1 || ram_addr !== 3'd0 || init_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset: rdy0=%b we=%b addr=%0d done=%b, want 0 1 0 0",
                     req0_ready, ram_we, ram_addr, init_done);
        end
        idle();
        tick();
        #4;
        tests_run++;
        if (rsp0_valid !== 1'b0 || rsp0_rdata !== 32'd0) begin
            tests_failed++;
            $display("FAIL dropped_rsp: v0=%b d0=%h, want 0 0", rsp0_valid, rsp0_rdata);
        end
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #4;
            tests_run++;
            if (ram_we !== 1'b1 || ram_addr !== 3'(i) || rsp0_valid !== 1'b0 ||
                rsp1_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL reinit[%0d]: we=%b addr=%0d v=%b%b, want 1 %0d 00",
                         i, ram_we, ram_addr, rsp1_valid, rsp0_valid, i);
            end
            tick();
        end
        #4;
        tests_run++;
        if (init_done !== 1'b1) begin
            tests_failed++;
            $display("FAIL reinit_done: done=%b, want 1", init_done);
        end
        tick();
    endtask

    task automatic test_init_request();
        drive0(1'b1, 1'b1, 3'd3, 32'h33);
        tick();
        idle();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        drive1(1'b1, 1'b0, 3'd3, 32'd0);
        for (int i = 0; i < 8; i++) begin
            #4;
            tests_run++;
            if ({req1_ready, req0_ready} !== 2'b00 || init_done !== 1'b0 || ram_addr !== 3'(i))
            begin
                tests_failed++;
                $display("FAIL init_block[%0d]: rdy=%b%b done=%b addr=%0d, want 00 0 %0d",
                         i, req1_ready, req0_ready, init_done, ram_addr, i);
            end
            tick();
        end
        #4;
        tests_run++;
        if (req1_ready !== 1'b1 || init_done !== 1'b1 || ram_addr !== 3'd3 || ram_we !== 1'b0) begin
            tests_failed++;
            $display("FAIL first_serve: rdy1=%b done=%b addr=%0d we=%b, want 1 1 3 0",
                     req1_ready, init_done, ram_addr, ram_we);
        end
        tick();
        idle();
        #4;
        tests_run++;
        if (rsp1_valid !== 1'b1 || rsp1_rdata !== 32'd0 || rsp0_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL first_serve_rsp: v1=%b d1=%h v0=%b, want 1 0 0",
                     rsp1_valid, rsp1_rdata, rsp0_valid);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_reads_zero();
        test_write_read();
        test_alternate();
        test_req1_only();
        test_reset_mid_read();
        test_init_request();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
